// File: rtl/pos_cell_reader.sv
// pos_cell_reader: reads a particle count from cell memory address 0, then streams position words 1..count.
// Latency: the first out_valid comes 6 cycles after start, then 1 beat per cycle while out_ready is held high.
// Backpressure: reads are throttled so that FIFO occupancy plus reads in flight never exceeds 4; the output holds while out_ready=0.
// Ports:
//   clock, rst_n                     - rising-edge clock, asynchronous active-low reset
//   start                            - pulse that begins a readout; ignored while busy
//   mem_address/mem_rden/mem_wren    - cell memory read port (2-cycle read latency); mem_wren is always 0
//   mem_q                            - cell memory read data
//   out_valid/out_ready              - valid/ready stream carrying out_data, out_index (1..count) and out_last
//   particle_count, busy, done       - latched count, readout-in-progress flag, one-cycle completion pulse
//   count_err                        - sticky; set when the raw count was clamped to PARTICLE_NUM-1
module pos_cell_reader #(
  parameter int DATA_WIDTH   = 96,
  parameter int ADDR_WIDTH   = 8,
  parameter int PARTICLE_NUM = 220
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_rden,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_index,
  output logic                  out_last,
  output logic [ADDR_WIDTH-1:0] particle_count,
  output logic                  busy,
  output logic                  done,
  output logic                  count_err
);

  localparam int AW1 = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] MAX_CNT = ADDR_WIDTH'(PARTICLE_NUM - 1);

  typedef enum logic [2:0] {IDLE, RD_CNT, WAIT_CNT, STREAM, FINISH} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [ADDR_WIDTH-1:0] index;
    logic                  last;
  } entry_t;

  state_t                state_q, state_d;
  logic [1:0]            rd_vld;            // shift register tracking reads in the memory pipeline
  logic [ADDR_WIDTH-1:0] rd_idx [2];        // address carried alongside each in-flight read
  logic [AW1-1:0]        rd_next;           // next stream address; one wider so count+1 fits
  entry_t                fifo_mem [4];
  logic [1:0]            wr_ptr, rd_ptr;
  logic [2:0]            fifo_cnt;

  logic                  issue;
  logic [ADDR_WIDTH-1:0] issue_addr;
  logic [ADDR_WIDTH-1:0] raw_cnt, cnt_sat;
  logic                  cnt_over, cnt_cap, push, pop, last_xfer, credit_ok;
  logic [3:0]            in_use;
  entry_t                head;

  assign mem_wren  = 1'b0;
  assign raw_cnt   = mem_q[ADDR_WIDTH-1:0];
  assign cnt_over  = raw_cnt > MAX_CNT;
  assign cnt_sat   = cnt_over ? MAX_CNT : raw_cnt;
  // The word returning while in WAIT_CNT is the count; while streaming it is a position.
  assign cnt_cap   = (state_q == WAIT_CNT) && rd_vld[1];
  assign push      = (state_q == STREAM) && rd_vld[1];
  assign out_valid = (fifo_cnt != 3'd0);
  assign pop       = out_valid && out_ready;
  assign head      = fifo_mem[rd_ptr];
  assign last_xfer = pop && head.last;

  // Every read either sits in the FIFO or is still in flight. A pop this cycle frees a slot
  // in time for the new read, which is what sustains one beat per cycle.
  assign in_use    = {1'b0, fifo_cnt} + 4'(mem_rden) + 4'(rd_vld[0]) + 4'(rd_vld[1]);
  assign credit_ok = in_use < (4'd4 + 4'(pop));

  // Output fields are forced to zero whenever there is no valid beat, which also covers reset.
  assign out_data  = out_valid ? head.data  : '0;
  assign out_index = out_valid ? head.index : '0;
  assign out_last  = out_valid ? head.last  : 1'b0;

  // State register
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start) state_d = RD_CNT;
      RD_CNT:   state_d = WAIT_CNT;
      WAIT_CNT: if (cnt_cap) state_d = (cnt_sat == '0) ? FINISH : STREAM;
      STREAM:   if (last_xfer) state_d = FINISH;
      FINISH:   state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Output and read-issue logic
  always_comb begin
    issue      = 1'b0;
    issue_addr = mem_address;
    busy       = (state_q != IDLE);
    done       = (state_q == FINISH);
    case (state_q)
      IDLE: begin
        if (start) begin
          issue      = 1'b1;
          issue_addr = '0;
        end
      end
      // Address 1 is issued on the same edge the count is captured, straight from mem_q.
      WAIT_CNT: begin
        if (cnt_cap && (cnt_sat != '0)) begin
          issue      = 1'b1;
          issue_addr = ADDR_WIDTH'(1);
        end
      end
      STREAM: begin
        if ((rd_next <= {1'b0, particle_count}) && credit_ok) begin
          issue      = 1'b1;
          issue_addr = rd_next[ADDR_WIDTH-1:0];
        end
      end
      default: ;
    endcase
  end

  // Read port, in-flight tracking and count capture
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      mem_rden       <= 1'b0;
      mem_address    <= '0;
      rd_vld         <= 2'b00;
      rd_idx[0]      <= '0;
      rd_idx[1]      <= '0;
      rd_next        <= '0;
      particle_count <= '0;
      count_err      <= 1'b0;
    end else begin
      mem_rden  <= issue;
      if (issue) mem_address <= issue_addr;
      rd_vld    <= {rd_vld[0], mem_rden};
      rd_idx[0] <= mem_address;
      rd_idx[1] <= rd_idx[0];
      if (cnt_cap) begin
        particle_count <= cnt_sat;
        rd_next        <= AW1'(2);
        if (cnt_over) count_err <= 1'b1;
      end else if (issue && (state_q == STREAM)) begin
        rd_next <= rd_next + AW1'(1);
      end
    end
  end

  // Skid FIFO control
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      fifo_cnt <= fifo_cnt + 3'(push) - 3'(pop);
    end
  end

  // Skid FIFO storage; contents are only observed through the valid-gated outputs.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr].data  <= mem_q;
      fifo_mem[wr_ptr].index <= rd_idx[1];
      fifo_mem[wr_ptr].last  <= (rd_idx[1] == particle_count);
    end
  end

endmodule
